// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains one at a time after a hold period, each gated by its stage_ready ack.
// Define RESET_SEQ_TIMEOUT_EN to enable the per-stage WAIT watchdog (timeout_err / err_stage).
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16,
    localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  CLK,
    input  logic                  IN_RST,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  timeout_err,
    output logic [IDX_W-1:0]      err_stage
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ON    = '1;

    if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 1 || CNT_W > 62 ||
        longint'(HOLD_CYCLES - 1) > CNT_MAX || longint'(TIMEOUT_CYCLES - 1) > CNT_MAX) begin : g_bad_param
        $error("reset_sequencer: illegal parameter combination");
    end

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt, w_idx_inc;
    logic [NUM_STAGES-1:0] r_stage_rst, w_stage_rst_nxt;
    logic                  r_all_ready, w_all_ready_nxt;
    logic                  w_ready_cur;
    logic                  w_timeout_hit;

    // Saturating increment: a stuck stage must never wrap the counter back into range.
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_ready_cur = stage_ready[r_idx];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_stage_rst_nxt = r_stage_rst;
        w_all_ready_nxt = r_all_ready;

        if (sw_reset_req) begin
            w_state_nxt     = S_HOLD;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            w_stage_rst_nxt = ALL_ON;
            w_all_ready_nxt = 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nxt        = S_WAIT;
                        w_cnt_nxt          = '0;
                        w_idx_nxt          = '0;
                        w_stage_rst_nxt    = ALL_ON;
                        w_stage_rst_nxt[0] = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_WAIT: begin
                    // An ack on the timeout cycle still wins over the watchdog.
                    if (w_ready_cur) begin
                        w_cnt_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt     = S_DONE;
                            w_all_ready_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = w_idx_inc;
                            for (int i = 0; i < NUM_STAGES; i++) begin
                                if (i == int'(w_idx_inc)) w_stage_rst_nxt[i] = 1'b0;
                            end
                        end
                    end else if (w_timeout_hit) begin
                        w_state_nxt     = S_ERROR;
                        w_stage_rst_nxt = ALL_ON;
                        w_all_ready_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_DONE: begin
                    if (stage_ready != ALL_ON) begin
                        w_state_nxt     = S_HOLD;
                        w_cnt_nxt       = '0;
                        w_idx_nxt       = '0;
                        w_stage_rst_nxt = ALL_ON;
                        w_all_ready_nxt = 1'b0;
                    end
                end
                S_ERROR: begin
                    w_stage_rst_nxt = ALL_ON;
                    w_all_ready_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt     = S_HOLD;
                    w_cnt_nxt       = '0;
                    w_idx_nxt       = '0;
                    w_stage_rst_nxt = ALL_ON;
                    w_all_ready_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge IN_RST) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (IN_RST) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stage_rst <= '1;
            r_all_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_stage_rst <= w_stage_rst_nxt;
            r_all_ready <= w_all_ready_nxt;
        end
    end

    assign stage_rst = r_stage_rst;
    assign all_ready = r_all_ready;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             r_timeout_err;
    logic [IDX_W-1:0] r_err_stage;
    logic             w_enter_error;

    assign w_timeout_hit = (r_cnt == TIMEOUT_LAST);
    assign w_enter_error = (r_state == S_WAIT) && !w_ready_cur && w_timeout_hit && !sw_reset_req;

    // The error flag is sticky; only a software request or IN_RST clears it.
    always_ff @(posedge CLK or posedge IN_RST) begin
        if (IN_RST) begin
            r_timeout_err <= 1'b0;
            r_err_stage   <= '0;
        end else if (sw_reset_req) begin
            r_timeout_err <= 1'b0;
        end else if (w_enter_error) begin
            r_timeout_err <= 1'b1;
            r_err_stage   <= r_idx;
        end
    end

    assign timeout_err = r_timeout_err;
    assign err_stage   = r_err_stage;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
    assign err_stage     = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, ready drop, slow ack, software request, async reset, watchdog.
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       IN_RST;
    logic       sw_reset_req;
    logic [3:0] stage_ready;
    logic [3:0] stage_rst;
    logic       all_ready;
    logic       timeout_err;
    logic [1:0] err_stage;

    int total = 0;
    int bad   = 0;

    reset_sequencer #(
        .NUM_STAGES    (4),
        .HOLD_CYCLES   (16),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (16)
    ) dut (
        .CLK         (CLK),
        .IN_RST      (IN_RST),
        .sw_reset_req(sw_reset_req),
        .stage_ready (stage_ready),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .timeout_err (timeout_err),
        .err_stage   (err_stage)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        IN_RST       = 1'b1;
        sw_reset_req = 1'b0;
        stage_ready  = 4'hF;
        step(2);
        check("rst_stage_rst", 32'(stage_rst), 32'hF);
        check("rst_all_ready", 32'(all_ready), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_err_stage", 32'(err_stage), 32'h0);

        // Power-up with all stages acknowledging immediately.
        @(negedge CLK);
        IN_RST = 1'b0;
        step(15);
        check("pu_edge15_rst", 32'(stage_rst), 32'hF);
        step(1);
        check("pu_edge16_rst", 32'(stage_rst), 32'hE);
        step(1);
        check("pu_edge17_rst", 32'(stage_rst), 32'hC);
        step(1);
        check("pu_edge18_rst", 32'(stage_rst), 32'h8);
        step(1);
        check("pu_edge19_rst", 32'(stage_rst), 32'h0);
        check("pu_edge19_ready", 32'(all_ready), 32'h0);
        step(1);
        check("pu_edge20_ready", 32'(all_ready), 32'h1);

        // One-cycle ready drop in DONE forces a full re-sequence.
        stage_ready = 4'b0111;
        step(1);
        check("drop_rst", 32'(stage_rst), 32'hF);
        check("drop_ready", 32'(all_ready), 32'h0);
        stage_ready = 4'hF;
        step(15);
        check("drop_hold_rst", 32'(stage_rst), 32'hF);
        step(1);
        check("drop_rel0_rst", 32'(stage_rst), 32'hE);
        step(3);
        check("drop_rel3_rst", 32'(stage_rst), 32'h0);
        check("drop_rel3_ready", 32'(all_ready), 32'h0);
        step(1);
        check("drop_done_ready", 32'(all_ready), 32'h1);

        // Slow acknowledge on stage 1.
        stage_ready = 4'b1101;
        step(1);
        check("slow_enter_rst", 32'(stage_rst), 32'hF);
        step(16);
        check("slow_rel0_rst", 32'(stage_rst), 32'hE);
        step(1);
        check("slow_wait1_rst", 32'(stage_rst), 32'hC);
        step(49);
        check("slow_held_rst", 32'(stage_rst), 32'hC);
        check("slow_held_ready", 32'(all_ready), 32'h0);
        check("slow_timeout_err", 32'(timeout_err), 32'h0);
        stage_ready = 4'hF;
        step(1);
        check("slow_rel2_rst", 32'(stage_rst), 32'h8);
        step(1);
        check("slow_rel3_rst", 32'(stage_rst), 32'h0);
        step(1);
        check("slow_done_ready", 32'(all_ready), 32'h1);

        // Software request from DONE, then again in WAIT(1) coincident with the stage-1 ack.
        sw_reset_req = 1'b1;
        stage_ready  = 4'b1101;
        step(1);
        check("sw_done_rst", 32'(stage_rst), 32'hF);
        check("sw_done_ready", 32'(all_ready), 32'h0);
        sw_reset_req = 1'b0;
        step(16);
        check("sw_rel0_rst", 32'(stage_rst), 32'hE);
        step(1);
        check("sw_wait1_rst", 32'(stage_rst), 32'hC);
        sw_reset_req = 1'b1;
        stage_ready  = 4'hF;
        step(1);
        check("sw_wins_rst", 32'(stage_rst), 32'hF);
        check("sw_wins_ready", 32'(all_ready), 32'h0);
        sw_reset_req = 1'b0;
        stage_ready  = 4'b1011;
        step(15);
        check("sw_rehold_rst", 32'(stage_rst), 32'hF);
        step(1);
        check("sw_rerel0_rst", 32'(stage_rst), 32'hE);
        step(2);
        check("sw_wait2_rst", 32'(stage_rst), 32'h8);
        step(3);
        check("sw_wait2_held", 32'(stage_rst), 32'h8);

        // Asynchronous reset mid-cycle while waiting on stage 2.
        @(negedge CLK);
        IN_RST = 1'b1;
        #1;
        check("async_rst", 32'(stage_rst), 32'hF);
        check("async_ready", 32'(all_ready), 32'h0);
        #2;
        IN_RST = 1'b0;
        step(15);
        check("async_hold_rst", 32'(stage_rst), 32'hF);
        step(1);
        check("async_rel0_rst", 32'(stage_rst), 32'hE);
        step(2);
        check("async_wait2_rst", 32'(stage_rst), 32'h8);

`ifdef RESET_SEQ_TIMEOUT_EN
        // Watchdog: stage 2 never acknowledges.
        step(63);
        check("wd_before_err", 32'(timeout_err), 32'h0);
        check("wd_before_rst", 32'(stage_rst), 32'h8);
        step(1);
        check("wd_err", 32'(timeout_err), 32'h1);
        check("wd_err_stage", 32'(err_stage), 32'h2);
        check("wd_err_rst", 32'(stage_rst), 32'hF);
        check("wd_err_ready", 32'(all_ready), 32'h0);
        stage_ready = 4'hF;
        step(2);
        check("wd_sticky_err", 32'(timeout_err), 32'h1);
        check("wd_sticky_rst", 32'(stage_rst), 32'hF);
        sw_reset_req = 1'b1;
        step(1);
        check("wd_clear_err", 32'(timeout_err), 32'h0);
        sw_reset_req = 1'b0;
        step(16);
        check("wd_reseq_rst", 32'(stage_rst), 32'hE);
        step(4);
        check("wd_reseq_ready", 32'(all_ready), 32'h1);
`else
        // Without the watchdog a missing ack is waited on indefinitely.
        step(1100);
        check("nowd_held_rst", 32'(stage_rst), 32'h8);
        check("nowd_timeout_err", 32'(timeout_err), 32'h0);
        check("nowd_err_stage", 32'(err_stage), 32'h0);
        stage_ready = 4'hF;
        step(1);
        check("nowd_rel3_rst", 32'(stage_rst), 32'h0);
        step(1);
        check("nowd_done_ready", 32'(all_ready), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
